addn_pipe: RTL
==============

# addn_pipe

Parametrised, pipelined successor to the fixed 8-bit combinational adder. Computes `a + b + cin` or `a - b - cin` over WIDTH bits, split into CHUNK-bit ripple stages with one register boundary per stage, and streams operands with a valid/ready handshake on both sides. It sits in the arithmetic benchmark set as the first sequential adder, providing the datapath exercised by the multi-test, self-checking benches.

## Interface
- WIDTH, 8, operand/result width; ≥ 1.
- CHUNK, 4, bits added per pipeline stage; 1 ≤ CHUNK ≤ WIDTH.
- STAGES (localparam), ceil(WIDTH/CHUNK), pipeline depth; the last chunk may be narrower than CHUNK.

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: add, 1: subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out of MSB (sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

## Operation
- Effective addition: `a + (sub ? ~b : b) + (sub ? ~cin : cin)`; add computes a+b+cin, sub computes a−b−cin.
- Stage k (0..STAGES−1) adds chunk k of A and effective B plus carry from stage k−1 (stage 0 uses effective cin); it registers its sum chunk, the carry, and the still-unprocessed high chunks of A and effective B (skew registers), plus the previously completed low sum chunks.
- The last stage also registers cout (carry out of bit WIDTH−1) and ovf = carry into MSB XOR carry out of MSB.
- Each stage has a valid bit; stage 0 valid loads in_valid & in_ready.
- Global enable: `en = !out_valid || out_ready`. in_ready = en. When en=1 every stage (valid and data) shifts one position; when en=0 all stages hold.
- Bubbles are not collapsed: an invalid stage occupies its slot and shifts like data.
- Stage data registers may load only when the incoming valid is 1; the valid bits alone are authoritative.
- sum/cout/ovf are the last-stage registers; they hold stable while out_valid=1 and out_ready=0.
- Full word results must equal a single-cycle WIDTH-bit add/sub for every input, including WIDTH not divisible by CHUNK.

## Timing
- Reset (rst_n=0 at a clock edge): all valid bits, sum, cout, ovf, and skew/carry registers clear to 0 at that edge. in_ready is combinational and reads 1 after reset because out_valid=0.
- Reset mid-operation discards all in-flight beats; no result for them ever appears.
- Latency: a beat accepted at edge N (in_valid & in_ready) appears with out_valid=1 after edge N+STAGES−1 when unstalled, i.e. STAGES register stages including the output.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: out_valid=1 & out_ready=0 implies in_ready=0 in the same cycle; the upstream beat must be held (standard valid/ready, no drops, no duplicates).
- Simultaneous output pop and input push in one cycle is allowed and is the steady state.
- in_valid may rise without waiting for in_ready; the beat transfers only on the edge where both are 1.
- The block does not depend on combinational paths from in_valid to out_*; the only combinational output is in_ready, driven from out_valid and out_ready.

## Test plan
- WIDTH=8, CHUNK=4, add, a=0xFF, b=0x00, cin=0 -> after 2 stages, sum=0xFF, cout=0, ovf=0.
- Add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- Sub a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0 (borrow). Sub a=0x80, b=0x01, cin=1 -> sum=0x7E, cout=1, ovf=1.
- Stream of 16 back-to-back random beats with out_ready toggling in a pseudo-random pattern -> all 16 results in order, each matching the reference model; sum/cout/ovf stable while stalled; in_ready=0 whenever out_valid=1 and out_ready=0.
- Reset pulse (rst_n=0 for 1 cycle) with 2 beats in flight -> out_valid=0 and sum/cout/ovf=0 after the edge; no stale result afterwards; the next beat has normal latency.
- WIDTH=13, CHUNK=4 (STAGES=4, last chunk 1 bit): a=0x1FFF, b=0x0001, add -> sum=0x0000, cout=1 after 4 stages; exhaustive-random 1000 beats match the model.

Source files
------------

// File: rtl/addn_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : addn_pipe
//  Description : Pipelined WIDTH-bit adder/subtractor. The operands are split
//                into CHUNK-bit slices, and each slice is added in its own
//                register stage by a ripple adder. The carry and the
//                not-yet-added high operand bits move forward through skew
//                registers. A valid/ready handshake sits on both sides, and
//                one global enable advances the whole pipeline.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//     WIDTH      operand/result width (>= 1)
//     CHUNK      bits added per pipeline stage (1 <= CHUNK <= WIDTH)
//  Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     in_valid   operand beat valid
//     in_ready   beat accepted this cycle (combinational from output side)
//     a, b       operands, unsigned or two's complement
//     cin        carry-in (add) / borrow-in (sub)
//     sub        0: a+b+cin, 1: a-b-cin
//     out_valid  result beat valid
//     out_ready  downstream accepts the result
//     sum        result bits
//     cout       carry out of MSB (for subtract: 1 = no borrow)
//     ovf        signed two's-complement overflow
// ============================================================================
module addn_pipe #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

   // Per-stage pipeline state. r_a/r_b carry the operands forward (B is
   // already inverted for subtract). Only the bits above the current stage's
   // slice are consumed downstream. r_sum accumulates the completed low
   // slices of the result.
   logic             r_vld [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_sum [STAGES];
   logic             r_c   [STAGES];
   logic             r_ovf;

   // A single enable stalls or advances every stage together. Bubbles are
   // kept in place rather than collapsed. This keeps the only combinational
   // output (in_ready) a function of the output side alone.
   logic w_en;

   assign w_en      = !r_vld[STAGES-1] || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r_vld[STAGES-1];
   assign sum       = r_sum[STAGES-1];
   assign cout      = r_c[STAGES-1];
   assign ovf       = r_ovf;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // This stage's slice [HI:LO]. The final slice may be narrower than CHUNK.
      localparam int LO = k * CHUNK;
      localparam int HI = ((k + 1) * CHUNK < WIDTH) ? (k + 1) * CHUNK - 1 : WIDTH - 1;
      localparam int CW = HI - LO + 1;

      logic [WIDTH-1:0] w_a_i;
      logic [WIDTH-1:0] w_b_i;
      logic [WIDTH-1:0] w_s_i;
      logic             w_c_i;
      logic             w_v_i;
      logic [CW:0]      w_add;

      if (k == 0) begin : g_first
         // Subtract is computed as a + ~b + ~cin.
         assign w_a_i = a;
         assign w_b_i = sub ? ~b : b;
         assign w_c_i = sub ^ cin;
         assign w_s_i = '0;
         assign w_v_i = in_valid & w_en;
      end else begin : g_next
         assign w_a_i = r_a[k-1];
         assign w_b_i = r_b[k-1];
         assign w_c_i = r_c[k-1];
         assign w_s_i = r_sum[k-1];
         assign w_v_i = r_vld[k-1];
      end

      assign w_add = {1'b0, w_a_i[HI:LO]} + {1'b0, w_b_i[HI:LO]} + {{CW{1'b0}}, w_c_i};

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
            r_c[k]   <= 1'b0;
         end else if (w_en) begin
            r_vld[k] <= w_v_i;
            // Data registers only load real beats. Bubbles leave the data
            // untouched, and the valid bit alone marks them as empty.
            if (w_v_i) begin
               r_a[k]   <= w_a_i;
               r_b[k]   <= w_b_i;
               // Slots at and above LO are still zero in w_s_i, so OR-ing
               // the new slice in is enough.
               r_sum[k] <= w_s_i | (WIDTH'(w_add[CW-1:0]) << LO);
               r_c[k]   <= w_add[CW];
            end
         end
      end

      if (k == STAGES - 1) begin : g_last
         // The carry into the MSB is recovered from the MSB sum bit:
         // s = a ^ b ^ c_in, so c_in = a ^ b ^ s.
         logic w_c_msb;
         assign w_c_msb = w_a_i[WIDTH-1] ^ w_b_i[WIDTH-1] ^ w_add[CW-1];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_ovf <= 1'b0;
            end else if (w_en && w_v_i) begin
               r_ovf <= w_c_msb ^ w_add[CW];
            end
         end
      end
   end

endmodule
`default_nettype wire
